// File: rtl/grid_reader_if.sv
// Handshake and memory-read bundle between grid_reader and its grid memory / pixel consumer.
// The master modport is the reader's view; slave is the environment's view.
interface grid_reader_if;
  logic       start;
  logic [9:0] rd_addr;
  logic       rd_data;
  logic       pix_valid;
  logic       pix_ready;
  logic [7:0] pix_data;
  logic [4:0] pix_x;
  logic [4:0] pix_y;
  logic       pix_last;
  logic       busy;
  logic       done;
  logic [9:0] ink_count;

  modport master (
    input  start, rd_data, pix_ready,
    output rd_addr, pix_valid, pix_data, pix_x, pix_y, pix_last, busy, done, ink_count
  );

  modport slave (
    output start, rd_data, pix_ready,
    input  rd_addr, pix_valid, pix_data, pix_x, pix_y, pix_last, busy, done, ink_count
  );
endinterface

// File: rtl/grid_reader.sv
// Streams a square 1-bit drawing grid out as 8-bit pixels in row-major order over a
// valid/ready handshake, counting drawn cells per scan.
module grid_reader #(
  parameter int unsigned GRID_SIZE = 28,
  parameter int unsigned NUM_CELLS = 784,
  parameter logic [7:0]  PIX_ON    = 8'd255,
  parameter logic [7:0]  PIX_OFF   = 8'd0
) (
  input logic           clk_i,
  input logic           rst_ni,
  grid_reader_if.master bus_io
);

  localparam logic [9:0] LastIdx = 10'(NUM_CELLS - 1);
  localparam logic [4:0] LastCol = 5'(GRID_SIZE - 1);

  typedef enum logic [2:0] {StIdle, StAddr, StCapt, StSend, StDone} state_e;

  state_e     state_q, state_d;
  logic [9:0] idx_q, idx_d;
  logic [4:0] x_q, x_d;
  logic [4:0] y_q, y_d;
  logic [9:0] run_q, run_d;
  logic [9:0] ink_q, ink_d;
  logic [7:0] pix_q, pix_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      idx_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      run_q   <= '0;
      ink_q   <= '0;
      pix_q   <= PIX_OFF;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      y_q     <= y_d;
      run_q   <= run_d;
      ink_q   <= ink_d;
      pix_q   <= pix_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    x_d     = x_q;
    y_d     = y_q;
    run_d   = run_q;
    ink_d   = ink_q;
    pix_d   = pix_q;

    unique case (state_q)
      StIdle: begin
        if (bus_io.start) begin
          idx_d   = '0;
          x_d     = '0;
          y_d     = '0;
          run_d   = '0;
          state_d = StAddr;
        end
      end
      // Memory has one cycle of read latency, so ADDR only presents idx and waits.
      StAddr: state_d = StCapt;
      StCapt: begin
        pix_d   = bus_io.rd_data ? PIX_ON : PIX_OFF;
        run_d   = run_q + {9'd0, bus_io.rd_data};
        state_d = StSend;
      end
      StSend: begin
        if (bus_io.pix_ready) begin
          if (idx_q == LastIdx) begin
            ink_d   = run_q;
            state_d = StDone;
          end else begin
            idx_d = idx_q + 10'd1;
            if (x_q == LastCol) begin
              x_d = '0;
              y_d = y_q + 5'd1;
            end else begin
              x_d = x_q + 5'd1;
            end
            state_d = StAddr;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign bus_io.rd_addr   = idx_q;
  assign bus_io.pix_valid = (state_q == StSend);
  assign bus_io.pix_last  = (state_q == StSend) && (idx_q == LastIdx);
  assign bus_io.pix_data  = pix_q;
  assign bus_io.pix_x     = x_q;
  assign bus_io.pix_y     = y_q;
  assign bus_io.busy      = (state_q != StIdle);
  assign bus_io.done      = (state_q == StDone);
  assign bus_io.ink_count = ink_q;

endmodule

// File: tb/tb_grid_reader.sv
// Directed bench for grid_reader: a registered 1-bit grid memory model plus per-scenario tasks.
module tb_grid_reader;
  localparam int N = 784;
  localparam int G = 28;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  grid_reader_if bus ();

  grid_reader dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus_io(bus)
  );

  logic mem [N];
  always @(posedge clk) bus.rd_data <= mem[bus.rd_addr];

  int checks = 0;
  int failures = 0;

  int n_pix, stall_err, pix_err, first_bad, done_cnt, done_cyc, last_cyc;
  bit timeout;
  logic [7:0] obs_data [N];
  logic [4:0] obs_x [N];
  logic [4:0] obs_y [N];

  // Runs one scan from a start pulse; records every transfer and tallies deviations
  // from the memory model. Optionally pulses start or reset once pixel k is on offer.
  task automatic stream_grid(input bit rand_ready, input int restart_at, input int abort_at);
    int cyc;
    bit held;
    logic [7:0] hd, ed;
    logic [4:0] hx, hy;
    logic hl;
    n_pix = 0; stall_err = 0; pix_err = 0; first_bad = -1;
    done_cnt = 0; done_cyc = -1; last_cyc = -1; timeout = 0;
    held = 0; hd = '0; hx = '0; hy = '0; hl = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    cyc = 1;
    forever begin
      rst_n = 1'b1;
      bus.start = 1'b0;
      if (bus.done === 1'b1) begin done_cnt++; done_cyc = cyc; end
      if (bus.busy !== 1'b1) break;
      if (bus.pix_valid === 1'b1) begin
        if (held && (bus.pix_data !== hd || bus.pix_x !== hx || bus.pix_y !== hy ||
                     bus.pix_last !== hl)) stall_err++;
        hd = bus.pix_data; hx = bus.pix_x; hy = bus.pix_y; hl = bus.pix_last;
        bus.pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (n_pix == restart_at) bus.start = 1'b1;
        if (n_pix == abort_at) rst_n = 1'b0;
        if (bus.pix_ready && rst_n) begin
          if (n_pix >= N) begin
            pix_err++;
          end else begin
            obs_data[n_pix] = bus.pix_data;
            obs_x[n_pix] = bus.pix_x;
            obs_y[n_pix] = bus.pix_y;
            ed = mem[n_pix] ? 8'd255 : 8'd0;
            if (bus.pix_data !== ed || bus.pix_x !== 5'(n_pix % G) ||
                bus.pix_y !== 5'(n_pix / G) || bus.rd_addr !== 10'(n_pix) ||
                bus.pix_last !== 1'(n_pix == N - 1)) begin
              if (pix_err == 0) first_bad = n_pix;
              pix_err++;
            end
          end
          n_pix++;
          last_cyc = cyc;
          held = 0;
        end else begin
          held = 1;
        end
      end else begin
        bus.pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        held = 0;
      end
      if (cyc > 20000) begin timeout = 1; break; end
      @(negedge clk);
      cyc++;
    end
    rst_n = 1'b1;
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b1;
    bus.pix_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h want=0", bus.busy); end
    checks++; if (bus.pix_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h want=0", bus.pix_valid); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0h want=0", bus.done); end
    checks++; if (bus.pix_last !== 1'b0) begin failures++; $display("FAIL reset_last got=%0h want=0", bus.pix_last); end
    checks++; if (bus.pix_data !== 8'd0) begin failures++; $display("FAIL reset_data got=%0d want=0", bus.pix_data); end
    checks++; if (bus.ink_count !== 10'd0) begin failures++; $display("FAIL reset_ink got=%0d want=0", bus.ink_count); end
    checks++; if (bus.rd_addr !== 10'd0) begin failures++; $display("FAIL reset_addr got=%0d want=0", bus.rd_addr); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_start_discard got=%0h want=0", bus.busy); end
  endtask

  task automatic test_empty_grid();
    for (int i = 0; i < N; i++) mem[i] = 1'b0;
    stream_grid(1'b0, -1, -1);
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL empty_timeout got=%0d want=0", timeout); end
    checks++; if (n_pix !== N) begin failures++; $display("FAIL empty_count got=%0d want=%0d", n_pix, N); end
    checks++; if (pix_err !== 0) begin failures++; $display("FAIL empty_pixels got=%0d bad (first %0d) want=0", pix_err, first_bad); end
    checks++; if (done_cyc !== 3 * N + 1) begin failures++; $display("FAIL empty_done_cycle got=%0d want=%0d", done_cyc, 3 * N + 1); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL empty_done_pulses got=%0d want=1", done_cnt); end
    checks++; if (bus.ink_count !== 10'd0) begin failures++; $display("FAIL empty_ink got=%0d want=0", bus.ink_count); end
    checks++; if (obs_x[N-1] !== 5'd27 || obs_y[N-1] !== 5'd27) begin failures++; $display("FAIL empty_last_xy got=%0d,%0d want=27,27", obs_x[N-1], obs_y[N-1]); end
  endtask

  task automatic test_sparse_grid();
    for (int i = 0; i < N; i++) mem[i] = 1'b0;
    mem[0] = 1'b1; mem[27] = 1'b1; mem[28] = 1'b1; mem[783] = 1'b1;
    stream_grid(1'b0, -1, -1);
    checks++; if (pix_err !== 0) begin failures++; $display("FAIL sparse_pixels got=%0d bad (first %0d) want=0", pix_err, first_bad); end
    checks++; if (obs_data[0] !== 8'd255 || obs_data[783] !== 8'd255) begin failures++; $display("FAIL sparse_ends got=%0d,%0d want=255,255", obs_data[0], obs_data[783]); end
    checks++; if (obs_data[27] !== 8'd255 || obs_x[27] !== 5'd27 || obs_y[27] !== 5'd0) begin failures++; $display("FAIL sparse_27 got=%0d x=%0d y=%0d want=255 x=27 y=0", obs_data[27], obs_x[27], obs_y[27]); end
    checks++; if (obs_data[28] !== 8'd255 || obs_x[28] !== 5'd0 || obs_y[28] !== 5'd1) begin failures++; $display("FAIL sparse_28 got=%0d x=%0d y=%0d want=255 x=0 y=1", obs_data[28], obs_x[28], obs_y[28]); end
    checks++; if (obs_data[1] !== 8'd0 || obs_data[29] !== 8'd0) begin failures++; $display("FAIL sparse_off got=%0d,%0d want=0,0", obs_data[1], obs_data[29]); end
    checks++; if (bus.ink_count !== 10'd4) begin failures++; $display("FAIL sparse_ink got=%0d want=4", bus.ink_count); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < N; i++) mem[i] = (i % 3 == 0);
    stream_grid(1'b1, -1, -1);
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL bp_timeout got=%0d want=0", timeout); end
    checks++; if (stall_err !== 0) begin failures++; $display("FAIL bp_stable got=%0d changes want=0", stall_err); end
    checks++; if (n_pix !== N) begin failures++; $display("FAIL bp_count got=%0d want=%0d", n_pix, N); end
    checks++; if (pix_err !== 0) begin failures++; $display("FAIL bp_pixels got=%0d bad (first %0d) want=0", pix_err, first_bad); end
    checks++; if (done_cyc !== last_cyc + 1) begin failures++; $display("FAIL bp_done_follow got=%0d want=%0d", done_cyc, last_cyc + 1); end
    checks++; if (bus.ink_count !== 10'd262) begin failures++; $display("FAIL bp_ink got=%0d want=262", bus.ink_count); end
  endtask

  task automatic test_restart_ignored();
    for (int i = 0; i < N; i++) mem[i] = (i < 10);
    stream_grid(1'b0, 100, -1);
    checks++; if (n_pix !== N) begin failures++; $display("FAIL restart_count got=%0d want=%0d", n_pix, N); end
    checks++; if (pix_err !== 0) begin failures++; $display("FAIL restart_pixels got=%0d bad (first %0d) want=0", pix_err, first_bad); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL restart_done_pulses got=%0d want=1", done_cnt); end
    checks++; if (done_cyc !== 3 * N + 1) begin failures++; $display("FAIL restart_done_cycle got=%0d want=%0d", done_cyc, 3 * N + 1); end
    checks++; if (bus.ink_count !== 10'd10) begin failures++; $display("FAIL restart_ink got=%0d want=10", bus.ink_count); end
  endtask

  task automatic test_reset_midscan();
    stream_grid(1'b0, -1, 400);
    checks++; if (n_pix !== 400) begin failures++; $display("FAIL abort_count got=%0d want=400", n_pix); end
    checks++; if (done_cnt !== 0) begin failures++; $display("FAIL abort_done got=%0d want=0", done_cnt); end
    checks++; if (bus.busy !== 1'b0 || bus.pix_valid !== 1'b0 || bus.pix_last !== 1'b0) begin failures++; $display("FAIL abort_flags got=busy%0h valid%0h last%0h want=000", bus.busy, bus.pix_valid, bus.pix_last); end
    checks++; if (bus.ink_count !== 10'd0) begin failures++; $display("FAIL abort_ink got=%0d want=0", bus.ink_count); end
    checks++; if (bus.pix_data !== 8'd0 || bus.rd_addr !== 10'd0) begin failures++; $display("FAIL abort_data_addr got=%0d,%0d want=0,0", bus.pix_data, bus.rd_addr); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL abort_no_done got=%0h want=0", bus.done); end
    stream_grid(1'b0, -1, -1);
    checks++; if (n_pix !== N || pix_err !== 0) begin failures++; $display("FAIL abort_rescan got=%0d pixels %0d bad want=%0d pixels 0 bad", n_pix, pix_err, N); end
    checks++; if (bus.ink_count !== 10'd10) begin failures++; $display("FAIL abort_rescan_ink got=%0d want=10", bus.ink_count); end
  endtask

  task automatic test_back_to_back_full();
    for (int i = 0; i < N; i++) mem[i] = 1'b1;
    stream_grid(1'b0, -1, -1);
    checks++; if (bus.ink_count !== 10'd784) begin failures++; $display("FAIL full1_ink got=%0d want=784", bus.ink_count); end
    checks++; if (obs_data[500] !== 8'd255) begin failures++; $display("FAIL full1_data got=%0d want=255", obs_data[500]); end
    repeat (5) @(negedge clk);
    checks++; if (bus.ink_count !== 10'd784 || bus.busy !== 1'b0) begin failures++; $display("FAIL full_hold got=%0d busy=%0h want=784 busy=0", bus.ink_count, bus.busy); end
    stream_grid(1'b1, -1, -1);
    checks++; if (n_pix !== N || pix_err !== 0) begin failures++; $display("FAIL full2_pixels got=%0d pixels %0d bad want=%0d pixels 0 bad", n_pix, pix_err, N); end
    checks++; if (bus.ink_count !== 10'd784) begin failures++; $display("FAIL full2_ink got=%0d want=784", bus.ink_count); end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.pix_ready = 1'b0;
    for (int i = 0; i < N; i++) mem[i] = 1'b0;
    @(negedge clk);
    test_reset();
    test_empty_grid();
    test_sparse_grid();
    test_backpressure();
    test_restart_ignored();
    test_reset_midscan();
    test_back_to_back_full();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
